lzc_norm_pipe: RTL

Parametrised, pipelined leading-one detector and normaliser for the FPU/ALU datapath. It is the generalised successor of the fixed 28-bit leftmost-'1' finder.
- Accepts a WIDTH-bit operand through a valid/ready handshake.
- Finds the normalisation target bit: leftmost '1' (unsigned) or leftmost bit differing from the MSB (signed).
- Returns the bit position, the left-shift amount and the normalised operand two cycles later, at full throughput.

---
 rtl/lzc_pkg.sv | 14 +
 rtl/lzc_find.sv | 46 ++++
 rtl/lzc_norm_pipe.sv | 120 ++++++++++++
 3 files changed

// File: rtl/lzc_pkg.sv
// Shared constants and helpers for the leading-one normaliser pipeline.
package lzc_pkg;

   localparam logic MODE_UNSIGNED = 1'b0;
   localparam logic MODE_SIGNED   = 1'b1;

   localparam int unsigned LZC_WIDTH = 28;

   // Position field width; a 1- or 2-bit field still needs one bit.
   function automatic int unsigned lzc_pos_w(input int unsigned w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/lzc_find.sv
// Combinational leftmost-'1' finder built as a recursive binary tree
// of OR-reduced halves.
module lzc_find
   import lzc_pkg::*;
#(
   parameter  int unsigned W  = LZC_WIDTH,
   localparam int unsigned PW = lzc_pos_w(W)
) (
   input  logic [W-1:0]  data,
   output logic [PW-1:0] pos,
   output logic          none
);

   if (W == 1) begin : g_leaf
      assign pos  = '0;
      assign none = ~data[0];
   end else begin : g_node
      // Low half is the largest power of two below W, so L fits in PW.
      localparam int unsigned L   = 1 << (PW - 1);
      localparam int unsigned H   = W - L;
      localparam int unsigned HPW = lzc_pos_w(H);
      localparam int unsigned LPW = lzc_pos_w(L);

      logic [HPW-1:0] pos_hi;
      logic [LPW-1:0] pos_lo;
      logic           none_hi;
      logic           none_lo;

      lzc_find #(.W(H)) u_hi (
         .data (data[W-1:L]),
         .pos  (pos_hi),
         .none (none_hi)
      );

      lzc_find #(.W(L)) u_lo (
         .data (data[L-1:0]),
         .pos  (pos_lo),
         .none (none_lo)
      );

      assign none = none_hi & none_lo;
      assign pos  = none_hi ? PW'(pos_lo)
                            : PW'(L) + PW'(pos_hi);
   end

endmodule

// File: rtl/lzc_norm_pipe.sv
// Two-stage leading-one detector and left normaliser with valid/ready.
// Optional LZC_TAG_EN carries a TAG_W-bit tag alongside each operand.
module lzc_norm_pipe
   import lzc_pkg::*;
#(
   parameter  int unsigned WIDTH = LZC_WIDTH,
`ifdef LZC_TAG_EN
   parameter  int unsigned TAG_W = 4,
`endif
   localparam int unsigned POS_W = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic             mode_i,
   input  logic [WIDTH-1:0] data_i,
`ifdef LZC_TAG_EN
   input  logic [TAG_W-1:0] tag_i,
   output logic [TAG_W-1:0] tag_o,
`endif
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [POS_W-1:0] pos_o,
   output logic [POS_W-1:0] shamt_o,
   output logic [WIDTH-1:0] norm_o,
   output logic             none_o
);

   logic             s1_valid;
   logic             s1_mode;
   logic [WIDTH-1:0] s1_data;
   logic [POS_W-1:0] s1_pos;
   logic             s1_none;
`ifdef LZC_TAG_EN
   logic [TAG_W-1:0] s1_tag;
`endif

   logic             s2_adv;
   logic             s1_adv;
   logic             accept;

   logic [WIDTH-1:0] find_in;
   logic [POS_W-1:0] find_pos;
   logic             find_none;

   logic [POS_W-1:0] top_idx;
   logic [POS_W-1:0] s2_shamt;
   logic [WIDTH-1:0] s2_norm;

   assign s2_adv     = ~out_valid_o | out_ready_i;
   assign s1_adv     = ~s1_valid | s2_adv;
   assign in_ready_o = s1_adv;
   assign accept     = in_valid_i & s1_adv;

   // Signed: look for the first bit that differs from the sign.
   assign find_in = (mode_i == MODE_SIGNED)
      ? {1'b0, data_i[WIDTH-2:0] ^ {(WIDTH-1){data_i[WIDTH-1]}}}
      : data_i;

   lzc_find #(.W(WIDTH)) u_find (
      .data (find_in),
      .pos  (find_pos),
      .none (find_none)
   );

   assign top_idx  = (s1_mode == MODE_SIGNED) ? POS_W'(WIDTH - 2)
                                              : POS_W'(WIDTH - 1);
   assign s2_shamt = s1_none ? '0 : top_idx - s1_pos;
   assign s2_norm  = s1_data << s2_shamt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid <= 1'b0;
         s1_mode  <= 1'b0;
         s1_data  <= '0;
         s1_pos   <= '0;
         s1_none  <= 1'b0;
`ifdef LZC_TAG_EN
         s1_tag   <= '0;
`endif
      end else if (s1_adv) begin
         s1_valid <= in_valid_i;
         if (accept) begin
            s1_mode <= mode_i;
            s1_data <= data_i;
            s1_pos  <= find_pos;
            s1_none <= find_none;
`ifdef LZC_TAG_EN
            s1_tag  <= tag_i;
`endif
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_valid_o <= 1'b0;
         pos_o       <= '0;
         shamt_o     <= '0;
         norm_o      <= '0;
         none_o      <= 1'b0;
`ifdef LZC_TAG_EN
         tag_o       <= '0;
`endif
      end else if (s2_adv) begin
         out_valid_o <= s1_valid;
         if (s1_valid) begin
            pos_o   <= s1_pos;
            shamt_o <= s2_shamt;
            norm_o  <= s2_norm;
            none_o  <= s1_none;
`ifdef LZC_TAG_EN
            tag_o   <= s1_tag;
`endif
         end
      end
   end

endmodule
